// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use hazard detection.
//               Optional performance counters under `define PERF_CNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [18:0]      id_ctrl_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic [XLEN-1:0]  id_rdata1_i,
  input  logic [XLEN-1:0]  id_rdata2_i,
  input  logic [XLEN-1:0]  id_imm_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [18:0]      ex_ctrl_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic [XLEN-1:0]  ex_rdata1_o,
  output logic [XLEN-1:0]  ex_rdata2_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic             valid_q,  valid_d;
  logic [18:0]      ctrl_q,   ctrl_d;
  logic [XLEN-1:0]  pc_q,     pc_d;
  logic [4:0]       rs1_q,    rs1_d;
  logic [4:0]       rs2_q,    rs2_d;
  logic [4:0]       rd_q,     rd_d;
  logic [XLEN-1:0]  rdata1_q, rdata1_d;
  logic [XLEN-1:0]  rdata2_q, rdata2_d;
  logic [XLEN-1:0]  imm_q,    imm_d;

  logic        load_use;
  logic        bubble;
  logic [18:0] ctrl_gated;

  // Conservative: rs fields are compared regardless of instruction format.
  assign load_use = valid_q & ctrl_q[16] & (rd_q != 5'd0) & id_valid_i &
                    ((rd_q == id_rs1_i) | (rd_q == id_rs2_i));

  assign stall_o = load_use & ~flush_i & ~hold_i;
  assign bubble  = flush_i | load_use;

  always_comb begin
    ctrl_gated      = id_ctrl_i;
    ctrl_gated[18]  = id_ctrl_i[18] & (id_rd_i != 5'd0) & id_valid_i;
    ctrl_gated[17]  = id_ctrl_i[17] & id_valid_i;
    ctrl_gated[16]  = id_ctrl_i[16] & id_valid_i;
    ctrl_gated[2:0] = id_ctrl_i[2:0] & {3{id_valid_i}};
  end

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    pc_d     = pc_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    if (!hold_i) begin
      pc_d     = id_pc_i;
      rs1_d    = id_rs1_i;
      rs2_d    = id_rs2_i;
      rd_d     = id_rd_i;
      rdata1_d = id_rdata1_i;
      rdata2_d = id_rdata2_i;
      imm_d    = id_imm_i;
      if (bubble) begin
        valid_d = 1'b0;
        ctrl_d  = 19'd0;
      end else begin
        valid_d = id_valid_i;
        ctrl_d  = ctrl_gated;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
    end
  end

  assign ex_valid_o  = valid_q;
  assign ex_ctrl_o   = ctrl_q;
  assign ex_pc_o     = pc_q;
  assign ex_rs1_o    = rs1_q;
  assign ex_rs2_o    = rs2_q;
  assign ex_rd_o     = rd_q;
  assign ex_rdata1_o = rdata1_q;
  assign ex_rdata2_o = rdata2_q;
  assign ex_imm_o    = imm_q;

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold_i) begin
      if (flush_i)       flush_cnt_d = flush_cnt_q + CNT_ONE;
      else if (load_use) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

`default_nettype wire
